// File: rtl/even_parity_serial_checker.sv
// ============================================================================
// even_parity_serial_checker : framed serial receiver with even-parity check
// Rev 1.0
// ============================================================================
`default_nettype none

module even_parity_serial_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              sin_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_LAST_BIT = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    err_cnt_d    = err_cnt_q;
    if (tick_i) begin
      case (state_q)
        S_IDLE: begin
          if (!sin_i) begin
            state_d = S_DATA;
            busy_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = sin_i;
          acc_d          = acc_q ^ sin_i;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == C_LAST_BIT) state_d = S_PARITY;
        end
        S_PARITY: begin
          perr_d  = acc_q ^ sin_i;
          state_d = S_STOP;
        end
        default: begin
          dout_d       = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~sin_i;
          valid_d      = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
          // Errored frames still deliver; the counter sticks at all-ones.
          if ((perr_q || !sin_i) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dout_o       = dout_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

`default_nettype wire

// File: doc/even_parity_serial_checker.md
Name: even_parity_serial_checker

Overview:
Receive-side counterpart of the 4-bit even parity bit generator. Deserialises a framed serial stream (start bit, DATA_W data bits LSB first, even parity bit, stop bit) and checks parity, rebuilding the parallel word. Reports parity and framing errors per frame and keeps a saturating error count. Advances only on sample ticks supplied by an external bit-rate enable.

Parameters:
DATA_W, 4, number of data bits per frame (>=1)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
tick  input  1  sample enable; sin is sampled only on clk edges where tick=1
sin  input  1  serial line, idle level 1
dout  output  DATA_W  last received data word, dout[0] = first data bit
valid  output  1  one-cycle pulse: new dout and error flags are available
parity_err  output  1  XOR of received data and parity bit was 1 (odd) for the last frame
frame_err  output  1  stop bit of the last frame was sampled as 0
busy  output  1  high from start-bit detection until the frame completes
err_cnt  output  CNT_W  count of frames with parity_err or frame_err, saturating

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; dout=0, valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0, bit counter and parity accumulator cleared. rst overrides tick.
- States: IDLE, DATA, PARITY, STOP. With tick=0, state, counter, shift register and accumulator hold. valid is 0 on every cycle except the completion cycle defined below.
- IDLE: tick && sin=0 -> DATA, busy=1, bit counter=0, accumulator=0. tick && sin=1 -> stay in IDLE.
- DATA: on each tick, shift register bit[counter] <= sin, accumulator ^= sin, counter++. The tick that samples bit DATA_W-1 moves to PARITY.
- PARITY: on tick, perr = accumulator ^ sin, then STOP.
- STOP: on tick, register dout <= shift register, parity_err <= perr, frame_err <= ~sin, valid <= 1, busy <= 0, then IDLE.
- If parity_err or frame_err is set, err_cnt increments in that same edge. It holds at 2^CNT_W-1 and does not wrap.
- Latency: valid rises on the clk edge that samples the stop bit. It is high for exactly one clk cycle, regardless of the tick spacing.
- dout, parity_err and frame_err hold their values until the next frame completes. They do not return to 0 after valid drops.
- A frame with errors is still delivered: valid=1 and dout is updated.
- Back-to-back frames: the next start bit may be sampled on the first tick after the STOP tick. No idle tick is needed between frames.
- Line break (sin held 0): the frame completes with frame_err=1. IDLE then treats the next low sample as a new start bit.
- rst mid-frame: the partial frame is discarded, with no valid pulse. dout, flags and err_cnt are cleared.

Test Plan:
- Reset: rst=1 for 3 cycles with sin toggling -> dout=0, valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0.
- Good frame, tick every cycle, sin sequence 0,1,1,0,1,1,1 (start, data 4'hB LSB first, parity 1, stop) -> one valid pulse on the stop-sample edge, dout=4'hB, parity_err=0, frame_err=0, err_cnt=0. busy is high for 6 cycles.
- Parity error: same frame with parity bit 0 -> dout=4'hB, parity_err=1, frame_err=0, err_cnt=1. A following good frame with data 4'h0 and parity 0 -> parity_err=0, err_cnt stays 1.
- Framing error: data 4'h5, parity 0, stop bit 0 -> dout=4'h5, frame_err=1, parity_err=0, err_cnt increments by 1.
- Exhaustive and back-to-back: all 16 data values, each with the generator's even parity, tick=1 every 4th cycle, no idle gaps -> 16 valid pulses, each 1 cycle wide, dout matching in order, no error flags.
- Reset mid-frame: rst after 2 data bits -> no valid pulse, busy=0. The next good frame with data 4'h9 and parity 0 -> dout=4'h9, no errors.
- Saturation: with CNT_W=2, send 5 parity-error frames -> err_cnt reads 1, 2, 3, 3, 3.
